// File: rtl/nibble_frame_rx.sv
// Nibble-lane receiver: packs low-nibble-first nibbles into bytes, then into one word per frame.
// Optional odd-parity check on each nibble is enabled by defining NIBBLE_FRAME_RX_PARITY_EN.
module nibble_frame_rx #(
  parameter int WORD_BYTES = 4,
  localparam int CW = $clog2(WORD_BYTES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    nib_valid,
  input  logic [3:0]              nib_data,
  input  logic                    nib_last,
`ifdef NIBBLE_FRAME_RX_PARITY_EN
  input  logic                    nib_par,
`endif
  output logic                    nib_ready,
  output logic                    word_valid,
  output logic [8*WORD_BYTES-1:0] word_data,
  output logic [CW-1:0]           word_bytes,
  output logic                    word_err,
  input  logic                    word_ready
);

  typedef enum logic [1:0] {
    COLLECT,
    DRAIN,
    HOLD
  } state_t;

  state_t                  state, state_n;
  logic [8*WORD_BYTES-1:0] acc, acc_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic                    half, half_n;
  logic                    err, err_n;
  logic                    accept;
  logic                    par_bad;

`ifdef NIBBLE_FRAME_RX_PARITY_EN
  assign par_bad = ~^{nib_par, nib_data};
`else
  assign par_bad = 1'b0;
`endif

  assign nib_ready = (state != HOLD) | word_ready;
  assign accept    = nib_valid & nib_ready;

  // NOTE: the accumulator is reset along with the control state because the
  // word bus must read 0 out of reset, not merely be ignored until valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= COLLECT;
      acc   <= '0;
      cnt   <= '0;
      half  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      half  <= half_n;
      err   <= err_n;
    end
  end

  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned; the blocking updates below deliberately chain, letting a
  // nibble arriving while HOLD drains land in the freshly cleared word.
  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    half_n  = half;
    err_n   = err;

    if (state == HOLD && word_ready) begin
      state_n = COLLECT;
      acc_n   = '0;
      cnt_n   = '0;
      half_n  = 1'b0;
      err_n   = 1'b0;
    end

    if (accept) begin
      err_n = err_n | par_bad;
      if (state_n == COLLECT) begin
        for (int k = 0; k < WORD_BYTES; k++) begin
          if (cnt_n == CW'(k)) begin
            if (half_n) acc_n[8*k+4 +: 4] = nib_data;
            else        acc_n[8*k   +: 4] = nib_data;
          end
        end
        if (half_n) cnt_n = cnt_n + 1'b1;
        half_n = ~half_n;
        if (nib_last) begin
          state_n = HOLD;
          // A pending low nibble means the frame had an odd nibble count.
          err_n   = err_n | half_n;
        end else if (cnt_n == CW'(WORD_BYTES)) begin
          state_n = DRAIN;
        end
      end else if (nib_last) begin
        state_n = HOLD;
        err_n   = 1'b1;
      end
    end
  end

  assign word_valid = (state == HOLD);
  assign word_data  = acc;
  assign word_bytes = cnt;
  assign word_err   = err;

endmodule

// File: tb/tb_nibble_frame_rx.sv
// Bench for nibble_frame_rx: frame-level reference model plus directed frames with literal expectations.
module tb_nibble_frame_rx;
  localparam int WB = 4;
  localparam int CW = $clog2(WB + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            nib_valid, nib_last, nib_par, word_ready;
  logic [3:0]      nib_data;
  logic            nib_ready, word_valid, word_err;
  logic [8*WB-1:0] word_data;
  logic [CW-1:0]   word_bytes;

  int n_cmp  = 0;
  int n_fail = 0;

  nibble_frame_rx #(.WORD_BYTES(WB)) dut (
    .clk        (clk),
    .rst        (rst),
    .nib_valid  (nib_valid),
    .nib_data   (nib_data),
    .nib_last   (nib_last),
`ifdef NIBBLE_FRAME_RX_PARITY_EN
    .nib_par    (nib_par),
`endif
    .nib_ready  (nib_ready),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_bytes (word_bytes),
    .word_err   (word_err),
    .word_ready (word_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  typedef struct {
    logic [8*WB-1:0] data;
    int              bytes;
    logic            err;
  } word_t;

  word_t      expq[$];
  logic [3:0] cur[$];
  logic       cur_perr;

  function automatic word_t build(input logic perr);
    word_t w;
    int n = cur.size();
    w.data = '0;
    for (int i = 0; i < n && i < 2*WB; i++) w.data[4*i +: 4] = cur[i];
    w.bytes = (n / 2 > WB) ? WB : n / 2;
    w.err   = (n % 2 == 1) || (n > 2*WB) || perr;
    return w;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      expq.delete();
      cur.delete();
      cur_perr = 1'b0;
    end else begin
      logic ready_m;
      ready_m = (expq.size() == 0) || word_ready;
      if (expq.size() > 0 && word_ready) void'(expq.pop_front());
      if (nib_valid && ready_m) begin
        cur.push_back(nib_data);
`ifdef NIBBLE_FRAME_RX_PARITY_EN
        if (^{nib_par, nib_data} == 1'b0) cur_perr = 1'b1;
`endif
        if (nib_last) begin
          expq.push_back(build(cur_perr));
          cur.delete();
          cur_perr = 1'b0;
        end
      end
    end
  end

  // Compare every cycle on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic held;
    held = (expq.size() != 0);
    check("word_valid", word_valid, held);
    check("nib_ready", nib_ready, !held || word_ready);
    if (held && word_valid) begin
      check("word_data", word_data, expq[0].data);
      check("word_bytes", word_bytes, expq[0].bytes);
      check("word_err", word_err, expq[0].err);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [3:0] d, input logic last, input logic bad = 1'b0);
    logic got = 1'b0;
    nib_valid = 1'b1;
    nib_data  = d;
    nib_last  = last;
    nib_par   = (~^d) ^ bad;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      got = nib_ready;
      tick();
    end
    if (!got) check("accept_timeout", 1'b0, 1'b1);
    nib_valid = 1'b0;
    nib_last  = 1'b0;
  endtask

  task automatic frame(input int n, input logic [3:0] first);
    logic [3:0] d = first;
    for (int i = 0; i < n; i++) begin
      put(d, i == n - 1);
      d = d + 4'd1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; nib_valid = 1'b0; nib_data = '0; nib_last = 1'b0;
    nib_par = 1'b0; word_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", word_valid, 1'b0);
    check("rst_data", word_data, 32'h0);
    check("rst_bytes", word_bytes, 0);
    check("rst_err", word_err, 1'b0);
    check("rst_ready", nib_ready, 1'b1);
    tick();
    rst = 1'b0;
    tick();

    // Full frame, valid for exactly one cycle.
    frame(8, 4'h1);
    check("full_valid", word_valid, 1'b1);
    check("full_data", word_data, 32'h87654321);
    check("full_bytes", word_bytes, 4);
    check("full_err", word_err, 1'b0);
    tick();
    check("full_one_cycle", word_valid, 1'b0);

    frame(4, 4'hA);
    check("short_data", word_data, 32'h0000DCBA);
    check("short_bytes", word_bytes, 2);
    check("short_err", word_err, 1'b0);
    tick();

    frame(3, 4'h5);
    check("odd_data", word_data, 32'h00000765);
    check("odd_bytes", word_bytes, 1);
    check("odd_err", word_err, 1'b1);
    tick();

    frame(10, 4'h1);
    check("ovf_data", word_data, 32'h87654321);
    check("ovf_bytes", word_bytes, 4);
    check("ovf_err", word_err, 1'b1);
    tick();

    // Backpressure, then release while the next frame's first nibble waits.
    word_ready = 1'b0;
    frame(2, 4'h3);
    repeat (5) begin
      check("bp_ready", nib_ready, 1'b0);
      check("bp_data", word_data, 32'h00000043);
      check("bp_valid", word_valid, 1'b1);
      tick();
    end
    nib_valid = 1'b1; nib_data = 4'h9; nib_last = 1'b0; nib_par = ~^4'h9;
    @(negedge clk);
    check("bp_blocked", nib_ready, 1'b0);
    tick();
    word_ready = 1'b1;
    @(negedge clk);
    check("bp_release", nib_ready, 1'b1);
    tick();
    nib_valid = 1'b0;
    check("bp_popped", word_valid, 1'b0);
    put(4'hA, 1'b1);
    check("bp_next_data", word_data, 32'h000000A9);
    check("bp_next_bytes", word_bytes, 1);
    tick();

    // Back-to-back frames of assorted lengths with no idle gap.
    for (int i = 1; i <= 5; i++) frame(i, 4'(i));
    tick();

    // Reset mid-frame.
    put(4'h1, 1'b0); put(4'h2, 1'b0); put(4'h3, 1'b0);
    rst = 1'b1;
    #1;
    check("rstmid_valid", word_valid, 1'b0);
    tick();
    check("rstmid_ready", nib_ready, 1'b1);
    rst = 1'b0;
    tick();
    frame(2, 4'hE);
    check("after_rst_data", word_data, 32'h000000FE);
    check("after_rst_bytes", word_bytes, 1);
    tick();

    // Reset while holding an unconsumed word.
    word_ready = 1'b0;
    frame(2, 4'h1);
    check("hold_valid", word_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("rsthold_valid", word_valid, 1'b0);
    check("rsthold_data", word_data, 32'h0);
    tick();
    rst = 1'b0;
    word_ready = 1'b1;
    tick();

`ifdef NIBBLE_FRAME_RX_PARITY_EN
    put(4'h2, 1'b0); put(4'h3, 1'b0, 1'b1); put(4'h4, 1'b0); put(4'h5, 1'b1);
    check("par_data", word_data, 32'h00005432);
    check("par_err", word_err, 1'b1);
    tick();
`endif

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
